// File: rtl/mem_access_unit_pkg.sv
// Shared types for the MEM-stage load/store unit.
// Size codes, FSM states and the alignment helper.
package cpu_mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam int OFF_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

  function automatic logic misaligned(
    input logic [1:0]       sz,
    input logic [OFF_W-1:0] off
  );
    logic m;
    m = 1'b0;
    unique case (sz)
      SZ_B: m = 1'b0;
      SZ_H: m = off[0];
      SZ_W: m = |off[1:0];
      SZ_D: m = |off;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline request/response and data-memory bus.
// slave = the unit, master = pipeline + memory side.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_fault;
  logic [63:0] mem_address;
  logic [63:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size,
    input  req_signed, req_addr, req_wdata,
    input  mem_rdata,
    output req_ready, resp_valid, resp_rdata,
    output resp_fault, mem_address, mem_wdata,
    output mem_read, mem_write
  );

  modport master (
    output req_valid, req_write, req_size,
    output req_signed, req_addr, req_wdata,
    output mem_rdata,
    input  req_ready, resp_valid, resp_rdata,
    input  resp_fault, mem_address, mem_wdata,
    input  mem_read, mem_write
  );
endinterface

// File: rtl/mem_access_unit_lane.sv
// Lane extract/extend for loads and lane merge
// for read-modify-write stores.
module mem_lane_align
  import cpu_mem_pkg::*;
(
  input  logic [63:0]      word_i,
  input  logic [63:0]      wdata_i,
  input  logic [1:0]       size_i,
  input  logic [OFF_W-1:0] off_i,
  input  logic             sgn_i,
  output logic [63:0]      load_o,
  output logic [63:0]      merge_o
);

  logic [5:0]  shamt;
  logic [63:0] shifted;
  logic [63:0] mask;

  // Shift lane down, extend, and build the merged word.
  always_comb begin
    shamt   = {off_i, 3'b000};
    shifted = word_i >> shamt;
    mask    = '1;
    load_o  = shifted;
    unique case (size_i)
      SZ_B: begin
        mask   = 64'h0000_0000_0000_00FF;
        load_o = sgn_i ? {{56{shifted[7]}}, shifted[7:0]}
                       : {56'd0, shifted[7:0]};
      end
      SZ_H: begin
        mask   = 64'h0000_0000_0000_FFFF;
        load_o = sgn_i ? {{48{shifted[15]}}, shifted[15:0]}
                       : {48'd0, shifted[15:0]};
      end
      SZ_W: begin
        mask   = 64'h0000_0000_FFFF_FFFF;
        load_o = sgn_i ? {{32{shifted[31]}}, shifted[31:0]}
                       : {32'd0, shifted[31:0]};
      end
      SZ_D: begin
        mask   = '1;
        load_o = shifted;
      end
    endcase
    merge_o = (word_i & ~(mask << shamt))
            | ((wdata_i & mask) << shamt);
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit driving the 64-bit
// word-indexed data memory; faults bypass memory.
module mem_access_unit
  import cpu_mem_pkg::*;
#(
  parameter int RD_LAT    = 1,
  parameter int MEM_WORDS = 32
) (
  input logic               clk,
  input logic               rst_n,
  mem_access_unit_if.slave  bus
);

  localparam int CW = 16;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             armed_q;
  logic             write_q;
  logic [1:0]       size_q;
  logic             sgn_q;
  logic [OFF_W-1:0] off_q;
  logic [60:0]      idx_q;
  logic [63:0]      wdata_q;
  logic [63:0]      word_q;
  logic             fault_q;

  logic        accept;
  logic        fault;
  logic        rd_last;
  logic [63:0] load_data;
  logic [63:0] merge_data;

  assign accept  = bus.req_valid && bus.req_ready;
  assign rd_last = (cnt_q == CW'(RD_LAT - 1));
  assign fault   = misaligned(bus.req_size, bus.req_addr[2:0])
                || (bus.req_addr[63:3] >= 61'(MEM_WORDS));

  mem_lane_align u_align (
    .word_i  (word_q),
    .wdata_i (wdata_q),
    .size_i  (size_q),
    .off_i   (off_q),
    .sgn_i   (sgn_q),
    .load_o  (load_data),
    .merge_o (merge_data)
  );

  // State and read-latency counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      armed_q <= 1'b1;
    end
  end

  // Next-state: route by fault, direction and size.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d = '0;
          if (fault)
            state_d = RESP;
          else if (bus.req_write && bus.req_size == SZ_D)
            state_d = WRITE;
          else
            state_d = READ;
        end
      end
      READ: begin
        if (rd_last)
          state_d = write_q ? WRITE : RESP;
        else
          cnt_d = cnt_q + 1'b1;
      end
      WRITE: state_d = RESP;
      RESP:  state_d = IDLE;
    endcase
  end

  // Request capture at acceptance; word capture on last READ cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q <= 1'b0;
      size_q  <= SZ_B;
      sgn_q   <= 1'b0;
      off_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      if (accept) begin
        write_q <= bus.req_write;
        size_q  <= bus.req_size;
        sgn_q   <= bus.req_signed;
        off_q   <= bus.req_addr[2:0];
        idx_q   <= bus.req_addr[63:3];
        wdata_q <= bus.req_wdata;
        fault_q <= fault;
      end
      if (state_q == READ && rd_last)
        word_q <= bus.mem_rdata;
    end
  end

  assign bus.req_ready   = armed_q && (state_q == IDLE);
  assign bus.mem_read    = (state_q == READ);
  assign bus.mem_write   = (state_q == WRITE);
  assign bus.mem_address = (state_q == READ || state_q == WRITE)
                         ? {3'b000, idx_q} : '0;
  assign bus.mem_wdata   = (state_q != WRITE) ? '0
                         : (size_q == SZ_D) ? wdata_q
                         : merge_data;
  assign bus.resp_valid  = (state_q == RESP);
  assign bus.resp_fault  = (state_q == RESP) && fault_q;
  assign bus.resp_rdata  = (state_q == RESP && !fault_q && !write_q)
                         ? load_data : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit (RD_LAT 1 and 3).
// Memories are preloaded with word j = j.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic preload = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_access_unit_if bus1 ();
  mem_access_unit_if bus3 ();

  mem_access_unit #(.RD_LAT(1), .MEM_WORDS(32)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );
  mem_access_unit #(.RD_LAT(3), .MEM_WORDS(32)) u3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3)
  );

  logic [63:0] mem1 [32];
  logic [63:0] mem3 [32];

  always @(posedge clk) begin
    if (preload) begin
      for (int j = 0; j < 32; j++) begin
        mem1[j] <= 64'(j);
        mem3[j] <= 64'(j);
      end
    end else begin
      if (bus1.mem_write) mem1[bus1.mem_address[4:0]] <= bus1.mem_wdata;
      if (bus3.mem_write) mem3[bus3.mem_address[4:0]] <= bus3.mem_wdata;
    end
  end

  assign bus1.mem_rdata = (bus1.mem_address < 64'd32)
                        ? mem1[bus1.mem_address[4:0]] : '0;
  assign bus3.mem_rdata = (bus3.mem_address < 64'd32)
                        ? mem3[bus3.mem_address[4:0]] : '0;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        f;
    logic [63:0] d;
    int          due;
  } exp_t;

  exp_t sb[$];

  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [63:0] rd_addr = '0;
  logic [63:0] wr_addr = '0;
  logic [63:0] wr_data = '0;
  int          resp_seen = 0;

  // Monitor: track memory traffic, check invariants, pop scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (bus1.mem_read) begin
      rd_cnt++;
      rd_addr = bus1.mem_address;
      chk("rw_exclusive", {63'd0, bus1.mem_write}, 64'd0);
    end
    if (bus1.mem_write) begin
      wr_cnt++;
      wr_addr = bus1.mem_address;
      wr_data = bus1.mem_wdata;
    end
    if (!bus1.mem_read && !bus1.mem_write) begin
      chk("idle_addr", bus1.mem_address, 64'd0);
      chk("idle_wdata", bus1.mem_wdata, 64'd0);
    end
    if (!bus1.resp_valid)
      chk("rdata_hold0", bus1.resp_rdata, 64'd0);
    if (bus1.resp_valid) begin
      resp_seen++;
      if (sb.size() == 0) begin
        chk("unexpected_resp", {63'd0, bus1.resp_valid}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("resp_rdata", bus1.resp_rdata, e.d);
        chk("resp_fault", {63'd0, bus1.resp_fault}, {63'd0, e.f});
        chk("resp_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic req(
    input logic w, input logic [1:0] sz, input logic sg,
    input logic [63:0] a, input logic [63:0] wd,
    input logic ef, input logic [63:0] ed, input int lat,
    input int erd, input int ewr,
    input logic [63:0] eaddr, input logic [63:0] ewd
  );
    int n;
    int seen;
    n = 0;
    @(negedge clk);
    #1;
    while (!bus1.req_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("ready_wait", {63'd0, bus1.req_ready}, 64'd1);
    rd_cnt = 0;
    wr_cnt = 0;
    seen = resp_seen;
    bus1.req_valid  = 1'b1;
    bus1.req_write  = w;
    bus1.req_size   = sz;
    bus1.req_signed = sg;
    bus1.req_addr   = a;
    bus1.req_wdata  = wd;
    sb.push_back('{f: ef, d: ed, due: cyc + lat});
    @(posedge clk);
    #1;
    bus1.req_valid = 1'b0;
    bus1.req_addr  = '1;
    bus1.req_wdata = '1;
    n = 0;
    while (resp_seen == seen && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("resp_timeout", {63'd0, resp_seen != seen}, 64'd1);
    chk("mem_read_cycles", 64'(rd_cnt), 64'(erd));
    chk("mem_write_cycles", 64'(wr_cnt), 64'(ewr));
    if (erd > 0) chk("read_index", rd_addr, eaddr);
    if (ewr > 0) begin
      chk("write_index", wr_addr, eaddr);
      chk("write_data", wr_data, ewd);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic [5:1] rdpat, rdypat, rvpat;
  logic [63:0] rd4, f4, a1;

  initial begin
    bus1.req_valid = 0; bus1.req_write = 0; bus1.req_size = 0;
    bus1.req_signed = 0; bus1.req_addr = 0; bus1.req_wdata = 0;
    bus3.req_valid = 0; bus3.req_write = 0; bus3.req_size = 0;
    bus3.req_signed = 0; bus3.req_addr = 0; bus3.req_wdata = 0;

    repeat (2) @(posedge clk);
    preload = 1'b0;
    @(negedge clk);
    chk("rst_ready", {63'd0, bus1.req_ready}, 64'd0);
    chk("rst_resp_valid", {63'd0, bus1.resp_valid}, 64'd0);
    chk("rst_mem_read", {63'd0, bus1.mem_read}, 64'd0);
    chk("rst_mem_write", {63'd0, bus1.mem_write}, 64'd0);
    chk("rst_mem_addr", bus1.mem_address, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", {63'd0, bus1.req_ready}, 64'd0);
    @(posedge clk);
    #1;
    chk("ready_after_edge", {63'd0, bus1.req_ready}, 64'd1);

    // w sz sg addr wdata | fault rdata lat rd wr idx wdata
    req(0, 2'd3, 0, 64'h28, 0, 0, 64'h5, 2, 1, 0, 64'd5, 0);
    req(1, 2'd0, 0, 64'h13, 64'hAB, 0, 0, 3, 1, 1, 64'd2,
        64'h0000_0000_AB00_0002);
    req(0, 2'd0, 1, 64'h13, 0, 0, 64'hFFFF_FFFF_FFFF_FFAB, 2, 1, 0,
        64'd2, 0);
    req(0, 2'd0, 0, 64'h13, 0, 0, 64'hAB, 2, 1, 0, 64'd2, 0);
    req(0, 2'd1, 0, 64'h12, 0, 0, 64'hAB00, 2, 1, 0, 64'd2, 0);
    req(0, 2'd1, 0, 64'h11, 0, 1, 0, 1, 0, 0, 0, 0);
    req(0, 2'd3, 0, 64'h100, 0, 1, 0, 1, 0, 0, 0, 0);
    req(1, 2'd3, 0, 64'h18, 64'h8899_AABB_CCDD_EEFF, 0, 0, 2, 0, 1,
        64'd3, 64'h8899_AABB_CCDD_EEFF);
    req(0, 2'd2, 1, 64'h1C, 0, 0, 64'hFFFF_FFFF_8899_AABB, 2, 1, 0,
        64'd3, 0);
    req(0, 2'd1, 0, 64'h1A, 0, 0, 64'hCCDD, 2, 1, 0, 64'd3, 0);
    req(1, 2'd1, 0, 64'h32, 64'h1234_BEEF, 0, 0, 3, 1, 1, 64'd6,
        64'h0000_0000_BEEF_0006);
    req(0, 2'd2, 0, 64'h30, 0, 0, 64'hBEEF_0006, 2, 1, 0, 64'd6, 0);
    req(1, 2'd2, 0, 64'h0A, 64'h55, 1, 0, 1, 0, 0, 0, 0);
    req(1, 2'd3, 0, 64'h108, 64'h77, 1, 0, 1, 0, 0, 0, 0);

    // RD_LAT = 3 instance: word load of the upper half of word 1.
    @(negedge clk);
    bus3.req_valid  = 1'b1;
    bus3.req_write  = 1'b0;
    bus3.req_size   = 2'd2;
    bus3.req_signed = 1'b0;
    bus3.req_addr   = 64'h0C;
    @(posedge clk);
    #1;
    bus3.req_valid = 1'b0;
    rd4 = '1;
    f4  = '1;
    a1  = '1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      rdpat[k]  = bus3.mem_read;
      rdypat[k] = bus3.req_ready;
      rvpat[k]  = bus3.resp_valid;
      if (k == 1) a1 = bus3.mem_address;
      if (k == 4) begin
        rd4 = bus3.resp_rdata;
        f4  = {63'd0, bus3.resp_fault};
      end
    end
    chk("lat3_read_pattern", {59'd0, rdpat}, 64'b00111);
    chk("lat3_ready_pattern", {59'd0, rdypat}, 64'b10000);
    chk("lat3_resp_pattern", {59'd0, rvpat}, 64'b01000);
    chk("lat3_index", a1, 64'd1);
    chk("lat3_rdata", rd4, 64'd0);
    chk("lat3_fault", f4, 64'd0);

    // Reset during READ of a byte store: nothing may be written.
    @(negedge clk);
    #1;
    wr_cnt = 0;
    bus1.req_valid  = 1'b1;
    bus1.req_write  = 1'b1;
    bus1.req_size   = 2'd0;
    bus1.req_signed = 1'b0;
    bus1.req_addr   = 64'h08;
    bus1.req_wdata  = 64'hCD;
    @(posedge clk);
    #1;
    bus1.req_valid = 1'b0;
    chk("midrst_in_read", {63'd0, bus1.mem_read}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", {63'd0, bus1.req_ready}, 64'd0);
    chk("midrst_mem_read", {63'd0, bus1.mem_read}, 64'd0);
    chk("midrst_mem_write", {63'd0, bus1.mem_write}, 64'd0);
    chk("midrst_mem_addr", bus1.mem_address, 64'd0);
    chk("midrst_mem_wdata", bus1.mem_wdata, 64'd0);
    chk("midrst_resp", {63'd0, bus1.resp_valid}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_ready_low", {63'd0, bus1.req_ready}, 64'd0);
    @(posedge clk);
    #1;
    chk("release_ready_high", {63'd0, bus1.req_ready}, 64'd1);
    repeat (4) @(negedge clk);
    chk("midrst_no_write", 64'(wr_cnt), 64'd0);
    chk("midrst_word1", mem1[1], 64'd1);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
